// File: rtl/lc3_mem_pkg.sv
// Shared constants for the LC-3 memory responder: FSM encodings, word width, wait-state bound.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lc3_mem_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam int LC3_WORD_W   = 16;
    localparam int LC3_WAIT_MAX = 15;

    // Bits needed to index/hold n distinct values, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage array: synchronous write, asynchronous read, no reset.
// Latency: write lands on the clock edge with we=1; read data follows addr combinationally.
// Backpressure: none; every write is accepted.
module mem_array
    import lc3_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WIDTH = LC3_WORD_W
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [clog2_min1(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; software owns initialisation.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// LC-3 MAR/MDR memory responder: latches one request, inserts WAIT_CYCLES wait states, pulses ready.
// Latency: request sampled at edge k -> ready high in the cycle after edge k+WAIT_CYCLES+1.
// Backpressure: requests only sampled in IDLE; mio_en outside IDLE is ignored, accesses cannot be cancelled.
module mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = LC3_WORD_W,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mio_en,
    input  logic                  r_w,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] d_o,
    output logic                  ready
);

    localparam int               CNT_W    = clog2_min1(WAIT_CYCLES + 1);
    localparam int               MEM_AW   = clog2_min1(MEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > LC3_WAIT_MAX) begin : g_bad_wait
        $error("mem_responder: WAIT_CYCLES must be within 0..15");
    end

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rw_q;
    logic [DATA_WIDTH-1:0] d_q;

    logic                  in_range;
    logic                  commit;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Unmapped addresses still run the full handshake but never touch the array.
    assign in_range = (32'(addr_q) < 32'(MEM_WORDS));
    assign commit   = (state == WAIT) && (cnt == '0);
    // Gated by state, so an asynchronous reset mid-access kills a pending write at once.
    assign mem_we   = commit && rw_q && in_range;

    mem_array #(
        .DEPTH (MEM_WORDS),
        .WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_q[MEM_AW-1:0]),
        .wdata (d_q),
        .rdata (mem_rdata)
    );

    // Access sequencer: latch request, count down wait states, commit, then one DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            ready  <= 1'b0;
            d_o    <= '0;
            addr_q <= '0;
            rw_q   <= 1'b0;
            d_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (mio_en) begin
                        addr_q <= addr;
                        rw_q   <= r_w;
                        d_q    <= d_i;
                        cnt    <= CNT_LOAD;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // ready is registered alongside the DONE transition: no path from mio_en.
                        state <= DONE;
                        ready <= 1'b1;
                        if (!rw_q) begin
                            d_o <= in_range ? mem_rdata : '0;
                        end
                    end
                end
                DONE: begin
                    ready <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // WAIT_CYCLES=2 instance
    logic        mio_en = 1'b0;
    logic        r_w    = 1'b0;
    logic [15:0] addr   = 16'h0;
    logic [15:0] d_i    = 16'h0;
    logic [15:0] d_o;
    logic        ready;

    // WAIT_CYCLES=0 instance
    logic        mio_en0 = 1'b0;
    logic        r_w0    = 1'b0;
    logic [15:0] addr0   = 16'h0;
    logic [15:0] d_i0    = 16'h0;
    logic [15:0] d_o0;
    logic        ready0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_WIDTH (16), .DATA_WIDTH (16), .MEM_WORDS (1024), .WAIT_CYCLES (2)
    ) u_dut (
        .clk (clk), .rst (rst), .mio_en (mio_en), .r_w (r_w),
        .addr (addr), .d_i (d_i), .d_o (d_o), .ready (ready)
    );

    mem_responder #(
        .ADDR_WIDTH (16), .DATA_WIDTH (16), .MEM_WORDS (1024), .WAIT_CYCLES (0)
    ) u_dut0 (
        .clk (clk), .rst (rst), .mio_en (mio_en0), .r_w (r_w0),
        .addr (addr0), .d_i (d_i0), .d_o (d_o0), .ready (ready0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access on the WAIT_CYCLES=2 instance. After sampling, mio_en drops and
    // addr/d_i/r_w are scrambled to prove they were latched. Returns edges from
    // sampling edge to ready (0 = never seen) and d_o in the ready cycle.
    task automatic do_access(input string tag, input logic rw, input logic [15:0] a,
                             input logic [15:0] d, input logic [15:0] a_during,
                             output int lat, output logic [15:0] rd);
        mio_en = 1'b1; r_w = rw; addr = a; d_i = d;
        tick();
        mio_en = 1'b0; r_w = ~rw; addr = a_during; d_i = ~d;
        lat = 0;
        rd  = 16'h0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ready) begin
                lat = i;
                rd  = d_o;
                break;
            end
        end
        check({tag, "_latency"}, lat, 3);
        tick();
        check({tag, "_pulse_width"}, {31'b0, ready}, 0);
    endtask

    int          lat;
    logic [15:0] rd;

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_ready",  {31'b0, ready},  0);
        check("rst_d_o",    {16'b0, d_o},    0);
        check("rst_ready0", {31'b0, ready0}, 0);
        check("rst_d_o0",   {16'b0, d_o0},   0);
        rst = 1'b0;
        tick();

        // Write then read, WAIT_CYCLES=2
        do_access("wr_beef", 1'b1, 16'h0010, 16'hBEEF, 16'h0011, lat, rd);
        do_access("rd_beef", 1'b0, 16'h0010, 16'h0000, 16'h0011, lat, rd);
        check("rd_beef_data", {16'b0, rd}, 32'hBEEF);

        // WAIT_CYCLES=0: preload then back-to-back reads with mio_en held high
        mio_en0 = 1'b1; r_w0 = 1'b1; addr0 = 16'h0003; d_i0 = 16'h1234;
        tick();
        mio_en0 = 1'b0;
        tick();
        check("w0_ready", {31'b0, ready0}, 1);
        tick();
        check("w0_ready_low", {31'b0, ready0}, 0);
        mio_en0 = 1'b1; r_w0 = 1'b0; addr0 = 16'h0003;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("b2b_ready_%0d", i), {31'b0, ready0}, (i % 3 == 1) ? 1 : 0);
            if (i % 3 == 1) check($sformatf("b2b_data_%0d", i), {16'b0, d_o0}, 32'h1234);
        end
        mio_en0 = 1'b0;
        tick();
        check("b2b_idle", {31'b0, ready0}, 0);

        // Latch check: addr moves to 6 during WAIT, mio_en already low
        do_access("pre5", 1'b1, 16'h0005, 16'h00AA, 16'h0000, lat, rd);
        do_access("pre6", 1'b1, 16'h0006, 16'h0BAD, 16'h0000, lat, rd);
        do_access("latch", 1'b0, 16'h0005, 16'h0000, 16'h0006, lat, rd);
        check("latch_data", {16'b0, rd}, 32'h00AA);

        // Unmapped address
        do_access("pre0", 1'b1, 16'h0000, 16'h7777, 16'h0001, lat, rd);
        do_access("um_wr", 1'b1, 16'h0400, 16'hFFFF, 16'h0000, lat, rd);
        do_access("um_rd", 1'b0, 16'h0400, 16'h0000, 16'h0000, lat, rd);
        check("um_rd_data", {16'b0, rd}, 32'h0000);
        do_access("mem0_rd", 1'b0, 16'h0000, 16'h0000, 16'h0400, lat, rd);
        check("mem0_data", {16'b0, rd}, 32'h7777);

        // Reset mid-access aborts an uncommitted write
        do_access("pre20", 1'b1, 16'h0020, 16'h0001, 16'h0000, lat, rd);
        mio_en = 1'b1; r_w = 1'b1; addr = 16'h0020; d_i = 16'h5555;
        tick();
        mio_en = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_ready", {31'b0, ready}, 0);
        check("mid_rst_d_o",   {16'b0, d_o},   0);
        tick();
        check("mid_rst_hold_ready", {31'b0, ready}, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("post_rst_ready_%0d", i), {31'b0, ready}, 0);
        end
        do_access("rd20", 1'b0, 16'h0020, 16'h0000, 16'h0021, lat, rd);
        check("rd20_data", {16'b0, rd}, 32'h0001);

        // Write does not disturb d_o
        do_access("pre1", 1'b1, 16'h0001, 16'h0042, 16'h0000, lat, rd);
        do_access("rd1", 1'b0, 16'h0001, 16'h0000, 16'h0002, lat, rd);
        check("rd1_data", {16'b0, rd}, 32'h0042);
        do_access("wr2", 1'b1, 16'h0002, 16'h0099, 16'h0001, lat, rd);
        check("wr2_d_o_at_ready", {16'b0, rd}, 32'h0042);
        tick();
        check("wr2_d_o_after", {16'b0, d_o}, 32'h0042);
        do_access("rd2", 1'b0, 16'h0002, 16'h0000, 16'h0001, lat, rd);
        check("rd2_data", {16'b0, rd}, 32'h0099);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
